mcu_event_tx: RTL
=================

Name: mcu_event_tx

Overview:
Parametrised event-to-MCU status messenger. It edge-detects N_EVT independent event inputs and queues each as a pending flag, so simultaneous events are never lost. Pending events are granted in fixed priority and each is sent as a one-byte code over a built-in UART serializer to the board MCU. Selected events raise a timed action pulse (e.g. ICAP reconfiguration start) once their byte has fully left the wire.

Parameters:
N_EVT, 8, number of event channels (1..16)
EVT_CODES, {8'h55,...}, N_EVT*8-bit flattened code table; channel i code = EVT_CODES[8*i+7:8*i]
LAUNCH_MASK, 0, N_EVT bits; bit i=1 means channel i triggers action_out after transmission
CLK_DIV, 434, clock cycles per UART bit (>=2)
HOLD_CYCLES, 200, action_out high duration in cycles (>=1)
IDW, $clog2(N_EVT) (min 1), width of action_id

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low
evt_in  in  N_EVT  event levels; rising edge = event
ovf_clr  in  1  clears overflow flags
mcu_tx  out  1  UART line to MCU, idle high
busy  out  1  high whenever state != IDLE
tx_done  out  1  one-cycle pulse at end of stop bit
pending  out  N_EVT  queued, not-yet-granted events
overflow  out  N_EVT  sticky: event re-occurred while already pending
action_out  out  1  timed action pulse
action_id  out  IDW  channel index that produced the current or last action_out

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, mcu_tx=1, busy=0, tx_done=0, pending=0, overflow=0, action_out=0, action_id=0; edge-detect register loads evt_in, so levels held through reset produce no event. Reset mid-frame aborts the frame; mcu_tx is 1 from the next edge.
- Edge detect: evt_in registered once (evt_q); event_i = evt_in[i] & ~evt_q[i].
- Pending: set on event_i. Cleared when channel i is granted. Set wins over grant-clear in the same cycle, so the bit stays 1.
- Overflow: overflow[i] set when event_i occurs while pending[i]=1 and pending[i] is not being cleared that cycle. No duplicate is queued. ovf_clr clears all bits; a same-cycle set wins.
- State machine IDLE / TX / HOLD:
  - IDLE, pending!=0: grant the lowest set index, latch code and index, go to TX.
  - TX: 10-bit frame, LSB first (start=0, d0..d7, stop=1). Each bit lasts exactly CLK_DIV cycles; bit and cycle counters are internal.
  - End of stop bit: tx_done pulses 1 cycle, then:
    - if LAUNCH_MASK[idx]=1, go to HOLD and load action_id=idx;
    - otherwise go to IDLE.
  - HOLD: action_out=1 for exactly HOLD_CYCLES cycles, then IDLE. Events keep queuing during TX and HOLD.
- Latency: event sampled at edge k → pending visible after edge k → grant at edge k+1 → mcu_tx low from edge k+2. Back-to-back frames, no launch: at most 1 IDLE cycle between stop bit end and the next start bit.
- action_out is registered, high only in HOLD; it is never high while mcu_tx is mid-frame.
- Arithmetic: counters sized by $clog2 of CLK_DIV, 10 and HOLD_CYCLES+1; no wrap-around within a frame.

Test Plan:
Settings: N_EVT=4, codes ch0..3 = AC/59/A6/55, LAUNCH_MASK=4'b1000, CLK_DIV=4, HOLD_CYCLES=8.
- Single event: rise on evt_in[1] → mcu_tx low 2 cycles later; bits 1,0,0,1,1,0,1,0 at 4 cycles each; stop high; tx_done one pulse 40 cycles after start; action_out stays 0.
- Launch event: rise on evt_in[3] → 0x55 frame, then action_out high exactly 8 cycles, action_id=3, busy low the cycle after.
- Simultaneous: evt_in[2] and evt_in[0] rise in the same cycle → frames AC then A6, ≤1 idle cycle between; overflow=0.
- Overflow: pulse evt_in[1] three times during one ch0 frame → one 0x59 frame only; overflow[1]=1 until ovf_clr, then 0.
- Reset: assert rst low mid-frame on bit 4, with evt_in[2] held high through reset → mcu_tx=1, pending=0 after the edge; no frame after release until a new rising edge.
- Grant/set collision: new ch0 edge in the exact grant cycle of ch0 → pending[0] stays 1; a second AC frame follows.

Source files
------------

// File: rtl/mcu_event_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : mcu_event_tx_if
// Brief    : Event inputs and MCU-side status/UART signals of mcu_event_tx,
//            bundled so the messenger and its user connect with one port.
// Revision : 1.0  initial release
// ============================================================================
interface mcu_event_tx_if #(
    parameter int N_EVT = 8,
    parameter int IDW   = 3
);
    logic [N_EVT-1:0] evt_in;
    logic             ovf_clr;
    logic             mcu_tx;
    logic             busy;
    logic             tx_done;
    logic [N_EVT-1:0] pending;
    logic [N_EVT-1:0] overflow;
    logic             action_out;
    logic [IDW-1:0]   action_id;

    // Messenger side: consumes events, produces UART line and status
    modport slave (
        input  evt_in, ovf_clr,
        output mcu_tx, busy, tx_done, pending, overflow, action_out, action_id
    );

    // Event-source / status-reader side
    modport master (
        output evt_in, ovf_clr,
        input  mcu_tx, busy, tx_done, pending, overflow, action_out, action_id
    );
endinterface
`default_nettype wire

// File: rtl/mcu_event_tx.sv
`default_nettype none
// ============================================================================
// Module   : mcu_event_tx
// Brief    : Edge-detects N_EVT event lines, queues them as pending flags,
//            sends each granted event as a one-byte UART code (8N1, LSB
//            first) and optionally raises a timed action pulse afterwards.
// Revision : 1.0  initial release
// ============================================================================
module mcu_event_tx #(
    parameter int                 N_EVT       = 8,
    parameter logic [N_EVT*8-1:0] EVT_CODES   = {N_EVT{8'h55}},
    parameter logic [N_EVT-1:0]   LAUNCH_MASK = '0,
    parameter int                 CLK_DIV     = 434,
    parameter int                 HOLD_CYCLES = 200,
    parameter int                 IDW         = (N_EVT > 1) ? $clog2(N_EVT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    mcu_event_tx_if.slave bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [CW-1:0] CYC_LAST  = CW'(CLK_DIV - 1);
    localparam logic [3:0]    BIT_LAST  = 4'd9;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TX   = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [N_EVT-1:0] evt_q;
    logic [N_EVT-1:0] pending_q, pending_d;
    logic [N_EVT-1:0] overflow_q, overflow_d;
    logic [N_EVT-1:0] evt_rise, grant_vec, ovf_set;
    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [3:0]       bit_q, bit_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [7:0]       code_q, code_d, grant_code;
    logic [IDW-1:0]   idx_q, idx_d, grant_idx;
    logic [IDW-1:0]   action_id_q, action_id_d;
    logic             mcu_tx_q, mcu_tx_d;
    logic             end_q, tx_done_q, action_q, action_d;
    logic             frame_end;
    logic [9:0]       frame;

    assign evt_rise = bus.evt_in & ~evt_q;
    assign frame    = {1'b1, code_q, 1'b0};

    // Lowest pending index wins; its code is looked up for latching at grant
    always_comb begin
        grant_idx  = '0;
        grant_code = 8'h00;
        for (int i = N_EVT - 1; i >= 0; i--) begin
            if (pending_q[i]) grant_idx = IDW'(i);
        end
        for (int i = 0; i < N_EVT; i++) begin
            if (grant_idx == IDW'(i)) grant_code = EVT_CODES[8*i +: 8];
        end
    end

    // Sequencer: IDLE grants, TX walks 10 bits of CLK_DIV cycles, HOLD times the action
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        bit_d       = bit_q;
        hold_d      = hold_q;
        code_d      = code_q;
        idx_d       = idx_q;
        action_id_d = action_id_q;
        grant_vec   = '0;
        frame_end   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    grant_vec[grant_idx] = 1'b1;
                    code_d  = grant_code;
                    idx_d   = grant_idx;
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = S_TX;
                end
            end
            S_TX: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (bit_q == BIT_LAST) begin
                        frame_end = 1'b1;
                        bit_d     = '0;
                        if (LAUNCH_MASK[idx_q]) begin
                            hold_d      = '0;
                            action_id_d = idx_q;
                            state_d     = S_HOLD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Event bookkeeping; a new edge always beats the grant-clear and ovf_clr
    always_comb begin
        ovf_set    = evt_rise & pending_q & ~grant_vec;
        pending_d  = (pending_q & ~grant_vec) | evt_rise;
        overflow_d = (bus.ovf_clr ? '0 : overflow_q) | ovf_set;
    end

    // The line is one cycle behind the sequencer, so tx_done and action_out
    // are delayed by one cycle too and line up with the real end of the stop bit
    always_comb begin
        mcu_tx_d = (state_q == S_TX) ? frame[bit_q] : 1'b1;
        action_d = (state_q == S_HOLD) && (hold_q != HOLD_LAST);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        evt_q <= bus.evt_in;
        if (!rst) begin
            pending_q   <= '0;
            overflow_q  <= '0;
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            bit_q       <= '0;
            hold_q      <= '0;
            code_q      <= 8'h00;
            idx_q       <= '0;
            action_id_q <= '0;
            mcu_tx_q    <= 1'b1;
            end_q       <= 1'b0;
            tx_done_q   <= 1'b0;
            action_q    <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            bit_q       <= bit_d;
            hold_q      <= hold_d;
            code_q      <= code_d;
            idx_q       <= idx_d;
            action_id_q <= action_id_d;
            mcu_tx_q    <= mcu_tx_d;
            end_q       <= frame_end;
            tx_done_q   <= end_q;
            action_q    <= action_d;
        end
    end

    assign bus.mcu_tx     = mcu_tx_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.tx_done    = tx_done_q;
    assign bus.pending    = pending_q;
    assign bus.overflow   = overflow_q;
    assign bus.action_out = action_q;
    assign bus.action_id  = action_id_q;
endmodule
`default_nettype wire
